input_conditioner: RTL and testbench

- Front-end stage directly upstream of the game datapath.
- Takes raw board pushbuttons and slide switches and synchronizes and debounces every bit.
- Each key press becomes exactly one single-cycle pulse on key0..key3. Switches become stable levels on sw0..sw3.
- Also generates the periodic battle-engine tick clkBE, a one-cycle enable, that the datapath consumes.

---
 rtl/input_conditioner.sv | 122 ++++++++++++
 tb/tb_input_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : input_conditioner                                            |
// | Description : Synchronizes and debounces raw keys/switches, turns key      |
// |               presses into single-cycle pulses and generates the clkBE     |
// |               battle-engine tick. Define KEY_ONEHOT_EN to keep only the    |
// |               lowest-index key pulse when several coincide.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic [3:0] SW,
  output logic       key0,
  output logic       key1,
  output logic       key2,
  output logic       key3,
  output logic       sw0,
  output logic       sw1,
  output logic       sw2,
  output logic       sw3,
  output logic       clkBE
);

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int              TK_W     = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST  = TK_W'(TICK_DIV - 1);
  localparam logic            KEY_IDLE = (KEY_ACTIVE_LOW != 0);
  localparam logic [7:0]      SYNC_RST = {4'b0000, {4{KEY_IDLE}}};

  logic [7:0]      r_sync1;
  logic [7:0]      r_sync2;
  logic [7:0]      w_norm;
  logic [7:0]      w_stable;
  logic [3:0]      r_key_prev;
  logic [3:0]      r_key_pulse;
  logic [3:0]      w_rise;
  logic [3:0]      w_pulse_next;
  logic [TK_W-1:0] r_tick_cnt;

  // Bits [3:0] are keys, [7:4] are switches; key flops idle at the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= {SW, KEY};
      r_sync2 <= r_sync1;
    end
  end

  assign w_norm = {r_sync2[7:4], r_sync2[3:0] ^ {4{KEY_IDLE}}};

  for (genvar i = 0; i < 8; i++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            r_stable;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_norm[i] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_stable <= w_norm[i];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end

    assign w_stable[i] = r_stable;
  end

  assign w_rise = w_stable[3:0] & ~r_key_prev;

`ifdef KEY_ONEHOT_EN
  // Isolate the lowest set bit; coincident higher-index presses are dropped.
  assign w_pulse_next = w_rise & (~w_rise + 4'd1);
`else
  assign w_pulse_next = w_rise;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_prev  <= 4'b0000;
      r_key_pulse <= 4'b0000;
    end else begin
      r_key_prev  <= w_stable[3:0];
      r_key_pulse <= w_pulse_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TK_W'(1);
    end
  end

  assign clkBE = (r_tick_cnt == TK_LAST);

  assign key0 = r_key_pulse[0];
  assign key1 = r_key_pulse[1];
  assign key2 = r_key_pulse[2];
  assign key3 = r_key_pulse[3];
  assign sw0  = w_stable[4];
  assign sw1  = w_stable[5];
  assign sw2  = w_stable[6];
  assign sw3  = w_stable[7];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_input_conditioner                                         |
// | Description : Scoreboard bench for input_conditioner (D=4, TICK_DIV=8).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [3:0] SW;
  logic       key0, key1, key2, key3;
  logic       sw0, sw1, sw2, sw3;
  logic       clkBE;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (8),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .KEY  (KEY),
    .SW   (SW),
    .key0 (key0),
    .key1 (key1),
    .key2 (key2),
    .key3 (key3),
    .sw0  (sw0),
    .sw1  (sw1),
    .sw2  (sw2),
    .sw3  (sw3),
    .clkBE(clkBE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ec;
    logic [3:0]  val;
  } ev_t;

  ev_t key_q[$];
  ev_t sw_q[$];

  int unsigned ec     = 0;  // posedges so far
  int unsigned rst_ec = 0;  // index of the last posedge that sampled reset
  int          n_cmp  = 0;
  int          n_bad  = 0;

  logic [3:0] exp_key;
  logic [3:0] exp_sw = 4'b0000;
  logic       exp_be;
  logic [3:0] got_key;
  logic [3:0] got_sw;

  always @(posedge clk) begin
    ec <= ec + 1;
    if (reset) rst_ec <= ec + 1;
  end

  // Monitor: outputs are compared every cycle against the queued expectations.
  always @(negedge clk) begin
    if (ec >= 1) begin
      exp_key = 4'b0000;
      while (key_q.size() > 0 && key_q[0].ec <= ec) begin
        exp_key = exp_key | key_q[0].val;
        void'(key_q.pop_front());
      end
      while (sw_q.size() > 0 && sw_q[0].ec <= ec) begin
        exp_sw = sw_q[0].val;
        void'(sw_q.pop_front());
      end
      exp_be  = (((ec - rst_ec) % 8) == 7);
      got_key = {key3, key2, key1, key0};
      got_sw  = {sw3, sw2, sw1, sw0};

      n_cmp++;
      if (got_key !== exp_key) begin
        n_bad++;
        $display("FAIL keys edge=%0d got=%b want=%b", ec, got_key, exp_key);
      end
      n_cmp++;
      if (got_sw !== exp_sw) begin
        n_bad++;
        $display("FAIL sws edge=%0d got=%b want=%b", ec, got_sw, exp_sw);
      end
      n_cmp++;
      if (clkBE !== exp_be) begin
        n_bad++;
        $display("FAIL clkBE edge=%0d got=%b want=%b", ec, clkBE, exp_be);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_key(input int unsigned at, input logic [3:0] v);
    ev_t e;
    e.ec  = at;
    e.val = v;
    key_q.push_back(e);
  endtask

  task automatic push_sw(input int unsigned at, input logic [3:0] v);
    ev_t e;
    e.ec  = at;
    e.val = v;
    sw_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    KEY   = 4'hF;
    SW    = 4'h0;
    cycles(2);
    reset = 1'b0;

    // 1: idle after reset; only clkBE activity expected.
    cycles(20);

    // 2: KEY[0] press/hold/release, then a second press.
    KEY[0] = 1'b0;
    push_key(ec + 7, 4'b0001);
    cycles(20);
    KEY[0] = 1'b1;
    cycles(10);
    KEY[0] = 1'b0;
    push_key(ec + 7, 4'b0001);
    cycles(12);
    KEY[0] = 1'b1;
    cycles(10);

    // 3: key bounce and short switch glitch are filtered out.
    KEY[1] = 1'b0;
    cycles(1);
    KEY[1] = 1'b1;
    cycles(1);
    KEY[1] = 1'b0;
    cycles(1);
    KEY[1] = 1'b1;
    cycles(2);
    SW[2] = 1'b1;
    cycles(3);
    SW[2] = 1'b0;
    cycles(10);

    // 4: two switches rise together; one falls later.
    SW[3] = 1'b1;
    SW[0] = 1'b1;
    push_sw(ec + 6, 4'b1001);
    cycles(12);
    SW[3] = 1'b0;
    push_sw(ec + 6, 4'b0001);
    cycles(10);
    SW[0] = 1'b0;
    push_sw(ec + 6, 4'b0000);
    cycles(10);

    // 5: simultaneous presses of KEY[2] and KEY[3].
    KEY[2] = 1'b0;
    KEY[3] = 1'b0;
`ifdef KEY_ONEHOT_EN
    push_key(ec + 7, 4'b0100);
`else
    push_key(ec + 7, 4'b1100);
`endif
    cycles(12);
    KEY[2] = 1'b1;
    KEY[3] = 1'b1;
    cycles(10);

    // 6: reset lands on edge 4 of a held press; the press restarts afterwards.
    cycles(3);
    KEY[0] = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    push_key(ec + 7, 4'b0001);
    cycles(15);
    KEY[0] = 1'b1;
    cycles(10);

    n_cmp++;
    if (key_q.size() != 0 || sw_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending got=%0d/%0d want=0/0", key_q.size(), sw_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
